hazard_unit: RTL and testbench

- Parametrised next-generation hazard, forwarding and multi-cycle scheduling block for the 5-stage MIPS pipeline. Its outputs feed the ID-stage operand muxes and the PC/IR write enables.
- Adds over the existing combinational control: forwarding with register-0 exclusion and valid qualification, load-use stall detection, taken-branch IF flush, and a counter-based scoreboard for multi-cycle MULT/DIV. The scoreboard stalls HI/LO readers and back-to-back mul/div until the result has landed.

---
 rtl/hazard_unit.sv | 189 ++++++++++++++++++
 tb/tb_hazard_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - hazard, forwarding and mul/div scoreboard for the 5-stage MIPS pipeline
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt are constant zero and no counter flops exist.
module hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int MUL_LAT    = 4,
   parameter int DIV_LAT    = 16,
   parameter int CNT_W      = 5,
   parameter int PERF_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_is_muldiv,
   input  logic                  id_is_div,
   input  logic                  id_reads_hilo,
   input  logic                  ex_valid,
   input  logic                  ex_write_reg,
   input  logic                  ex_mem_to_reg,
   input  logic [REG_ADDR_W-1:0] ex_des_r,
   input  logic                  mem_valid,
   input  logic                  mem_write_reg,
   input  logic                  mem_mem_to_reg,
   input  logic [REG_ADDR_W-1:0] mem_des_r,
   input  logic                  branch_taken,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  stall,
   output logic                  flush_if,
   output logic                  md_start,
   output logic                  md_busy,
   output logic                  md_done,
   output logic [PERF_W-1:0]     stall_cnt,
   output logic [PERF_W-1:0]     flush_cnt
);

   // Operand source encodings driven onto fwd_a / fwd_b
   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_EX    = 2'd1;
   localparam logic [1:0] FWD_MEM   = 2'd2;
   localparam logic [1:0] FWD_LOAD  = 2'd3;

   // Counter reload values: the counter reaches zero in the last execute cycle
   localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   logic ex_prod;
   logic mem_prod;
   logic load_use;
   logic sb_stall;

   // A producer is only eligible when it is a real instruction writing the regfile
   assign ex_prod  = ex_valid  & ex_write_reg;
   assign mem_prod = mem_valid & mem_write_reg;

   // Select the freshest source for one operand; r0 is hardwired so never forwarded
   function automatic logic [1:0] fwd_sel(
      input logic                  used,
      input logic [REG_ADDR_W-1:0] src,
      input logic                  valid,
      input logic                  ex_p,
      input logic [REG_ADDR_W-1:0] ex_d,
      input logic                  mem_p,
      input logic [REG_ADDR_W-1:0] mem_d,
      input logic                  mem_ld
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (valid && used && (src != '0)) begin
         if (ex_p && (ex_d == src)) begin
            sel = FWD_EX;
         end else if (mem_p && (mem_d == src)) begin
            sel = mem_ld ? FWD_LOAD : FWD_MEM;
         end
      end
      return sel;
   endfunction

   // Operand mux selects for the ID stage
   always_comb begin
      fwd_a = fwd_sel(id_uses_rs, id_rs, id_valid, ex_prod, ex_des_r,
                      mem_prod, mem_des_r, mem_mem_to_reg);
      fwd_b = fwd_sel(id_uses_rt, id_rt, id_valid, ex_prod, ex_des_r,
                      mem_prod, mem_des_r, mem_mem_to_reg);
   end

   // Stall sources: load data not yet available, or HI/LO / mul-div unit still occupied
   always_comb begin
      load_use = id_valid & ex_valid & ex_mem_to_reg & (ex_des_r != '0) &
                 ((id_uses_rs & (id_rs == ex_des_r)) |
                  (id_uses_rt & (id_rt == ex_des_r)));
      sb_stall = (state_q == BUSY) & id_valid & (id_is_muldiv | id_reads_hilo);
      stall    = load_use | sb_stall;
      flush_if = branch_taken & id_valid & ~stall;
      md_start = (state_q == IDLE) & id_valid & id_is_muldiv & ~stall;
   end

   // Scoreboard next state: load latency on launch, count down to the done cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (md_start) begin
               state_d = BUSY;
               cnt_d   = id_is_div ? DIV_LD : MUL_LD;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      done_d = (state_d == BUSY) && (cnt_d == '0);
   end

   // Scoreboard registers; reset aborts any in-flight operation without a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign md_busy = (state_q == BUSY);
   assign md_done = done_q;

`ifdef HAZ_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters for stall and IF flush cycles
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
      if (flush_if && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + PERF_W'(1);
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed and randomized self-checking bench for hazard_unit
module tb_hazard_unit;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 16;
   localparam int PERF_W  = 2;
   localparam int PERF_MAX = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div, id_reads_hilo;
   logic [4:0] id_rs, id_rt, ex_des_r, mem_des_r;
   logic       ex_valid, ex_write_reg, ex_mem_to_reg;
   logic       mem_valid, mem_write_reg, mem_mem_to_reg;
   logic       branch_taken;
   logic [1:0] fwd_a, fwd_b;
   logic       stall, flush_if, md_start, md_busy, md_done;
   logic [PERF_W-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model state: cycle index and the window of the outstanding mul/div
   int cyc;
   int st_c, en_c;
   int exp_sc, exp_fc;

   always #5 clk = ~clk;

   hazard_unit #(
      .REG_ADDR_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_is_muldiv(id_is_muldiv), .id_is_div(id_is_div), .id_reads_hilo(id_reads_hilo),
      .ex_valid(ex_valid), .ex_write_reg(ex_write_reg), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_des_r(ex_des_r),
      .mem_valid(mem_valid), .mem_write_reg(mem_write_reg), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_des_r(mem_des_r),
      .branch_taken(branch_taken),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush_if(flush_if),
      .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clr();
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_is_muldiv = 0; id_is_div = 0; id_reads_hilo = 0;
      ex_valid = 0; ex_write_reg = 0; ex_mem_to_reg = 0; ex_des_r = 0;
      mem_valid = 0; mem_write_reg = 0; mem_mem_to_reg = 0; mem_des_r = 0;
      branch_taken = 0;
   endtask

   task automatic model_reset();
      st_c = -100; en_c = -100; exp_sc = 0; exp_fc = 0;
   endtask

   // which source holds the newest value of register r as seen from ID
   function automatic int ref_fwd(input logic used, input logic [4:0] r);
      if (!id_valid || !used || r == 0) return 0;
      if (ex_valid && ex_write_reg && ex_des_r == r) return 1;
      if (mem_valid && mem_write_reg && mem_des_r == r) return mem_mem_to_reg ? 3 : 2;
      return 0;
   endfunction

   // one pipeline cycle: check combinational and registered outputs, advance model
   task automatic step();
      bit busy, done, lu, sb, e_stall, e_start, e_flush;
      @(negedge clk);
      busy = (cyc > st_c) && (cyc <= en_c);
      done = busy && (cyc == en_c);
      lu = id_valid && ex_valid && ex_mem_to_reg && ex_des_r != 0 &&
           ((id_uses_rs && id_rs == ex_des_r) || (id_uses_rt && id_rt == ex_des_r));
      sb = busy && id_valid && (id_is_muldiv || id_reads_hilo);
      e_stall = lu || sb;
      e_start = !busy && id_valid && id_is_muldiv && !e_stall;
      e_flush = branch_taken && id_valid && !e_stall;
      chk("fwd_a", 32'(fwd_a), 32'(ref_fwd(id_uses_rs, id_rs)));
      chk("fwd_b", 32'(fwd_b), 32'(ref_fwd(id_uses_rt, id_rt)));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("flush_if", 32'(flush_if), 32'(e_flush));
      chk("md_start", 32'(md_start), 32'(e_start));
      chk("md_busy", 32'(md_busy), 32'(busy));
      chk("md_done", 32'(md_done), 32'(done));
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(exp_fc));
      if (e_start) begin
         st_c = cyc;
         en_c = cyc + (id_is_div ? DIV_LAT : MUL_LAT);
      end
`ifdef HAZ_PERF_CNT_EN
      if (e_stall && exp_sc < PERF_MAX) exp_sc++;
      if (e_flush && exp_fc < PERF_MAX) exp_fc++;
`endif
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt);
      id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rs = 1; id_uses_rt = 1;
   endtask

   initial begin
      clr();
      rst_n = 0;
      cyc = 0;
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_fwd_a", 32'(fwd_a), 0);
      chk("rst_fwd_b", 32'(fwd_b), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_flush", 32'(flush_if), 0);
      chk("rst_md_busy", 32'(md_busy), 0);
      chk("rst_md_done", 32'(md_done), 0);
      chk("rst_md_start", 32'(md_start), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      chk("rst_flush_cnt", 32'(flush_cnt), 0);
      @(posedge clk); #1;
      rst_n = 1;

      // EX forwarding to both operands, then r0 exclusion
      set_id(5'd8, 5'd8);
      ex_valid = 1; ex_write_reg = 1; ex_des_r = 5'd8;
      step();
      chk("fwd_ex_a", 32'(fwd_a), 1);
      id_rs = 0; id_rt = 0; ex_des_r = 0;
      step();

      // EX over MEM priority, then MEM ALU, then MEM load
      clr();
      set_id(5'd3, 5'd4);
      ex_valid = 1; ex_write_reg = 1; ex_des_r = 5'd3;
      mem_valid = 1; mem_write_reg = 1; mem_des_r = 5'd3;
      step();
      ex_valid = 0;
      step();
      mem_mem_to_reg = 1;
      step();

      // load-use with a taken branch in ID: one stall cycle, then load forwarding
      clr();
      set_id(5'd5, 5'd1);
      branch_taken = 1;
      ex_valid = 1; ex_write_reg = 1; ex_mem_to_reg = 1; ex_des_r = 5'd5;
      step();
      ex_valid = 0; ex_mem_to_reg = 0;
      mem_valid = 1; mem_write_reg = 1; mem_mem_to_reg = 1; mem_des_r = 5'd5;
      step();
      chk("lu_fwd_load", 32'(fwd_a), 3);

      // MULT then MFLO waiting in ID until the result lands
      clr();
      id_valid = 1; id_is_muldiv = 1;
      step();
      clr();
      id_valid = 1; id_reads_hilo = 1;
      repeat (MUL_LAT + 2) step();

      // DIV, then a second DIV that arrives in the done cycle
      clr();
      id_valid = 1; id_is_muldiv = 1; id_is_div = 1;
      step();
      clr();
      repeat (DIV_LAT - 1) step();
      id_valid = 1; id_is_muldiv = 1; id_is_div = 1;
      step();
      step();
      clr();
      repeat (2) step();

      // reset while BUSY: busy drops immediately, no done pulse
      rst_n = 0;
      #2;
      chk("rstmid_busy", 32'(md_busy), 0);
      chk("rstmid_done", 32'(md_done), 0);
      @(posedge clk); #1;
      chk("rstmid_done2", 32'(md_done), 0);
      rst_n = 1;
      model_reset();

      // five consecutive load-use stalls then one taken branch
      set_id(5'd7, 5'd7);
      ex_valid = 1; ex_write_reg = 1; ex_mem_to_reg = 1; ex_des_r = 5'd7;
      repeat (5) step();
      clr();
      id_valid = 1; branch_taken = 1;
      step();
      clr();
      step();

      // randomized traffic with few register names to force collisions
      for (int i = 0; i < 400; i++) begin
         id_valid       = 1'($urandom_range(0, 3) != 0);
         id_rs          = 5'($urandom_range(0, 3));
         id_rt          = 5'($urandom_range(0, 3));
         id_uses_rs     = 1'($urandom_range(0, 1));
         id_uses_rt     = 1'($urandom_range(0, 1));
         id_is_muldiv   = 1'($urandom_range(0, 7) == 0);
         id_is_div      = 1'($urandom_range(0, 1));
         id_reads_hilo  = 1'($urandom_range(0, 5) == 0);
         ex_valid       = 1'($urandom_range(0, 1));
         ex_write_reg   = 1'($urandom_range(0, 3) != 0);
         ex_mem_to_reg  = 1'($urandom_range(0, 2) == 0);
         ex_des_r       = 5'($urandom_range(0, 3));
         mem_valid      = 1'($urandom_range(0, 1));
         mem_write_reg  = 1'($urandom_range(0, 3) != 0);
         mem_mem_to_reg = 1'($urandom_range(0, 1));
         mem_des_r      = 5'($urandom_range(0, 3));
         branch_taken   = 1'($urandom_range(0, 3) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
